// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq: 32/32 sequential restoring divider, signed or unsigned, one quotient
// bit per clock.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   ena          : downstream acknowledge, lets the FSM leave DONE
//   signed_div_i : 1 = two's-complement division, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high until ready_o is seen
//   annul_i      : abort an in-flight division
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result_o valid (DONE state), registered
// -----------------------------------------------------------------------------
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_rem;      // partial remainder always fits in W bits (it is below the divisor)
    logic          r_signed;
    logic          r_sign1;
    logic          r_sign2;
    logic [2*W-1:0] r_result;
    logic          r_ready;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_qbit;
    logic [W-1:0]  w_abs1;
    logic [W-1:0]  w_abs2;
    logic [W-1:0]  w_quot;
    logic [W-1:0]  w_rmd;

    assign result_o = r_result;
    assign ready_o  = r_ready;

    // Operand magnitudes loaded at acceptance
    assign w_abs1 = (signed_div_i && opdata1_i[W-1]) ? (~opdata1_i + W'(1)) : opdata1_i;
    assign w_abs2 = (signed_div_i && opdata2_i[W-1]) ? (~opdata2_i + W'(1)) : opdata2_i;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    // The 33-bit difference is negative exactly when its top bit is set.
    assign w_shift = {r_rem, r_dvd[W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_qbit  = ~w_diff[W];

    // Sign correction of the finished magnitudes
    assign w_quot = (r_signed && (r_sign1 ^ r_sign2)) ? (~r_dvd + W'(1)) : r_dvd;
    assign w_rmd  = (r_signed && r_sign1) ? (~r_rem + W'(1)) : r_rem;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            // Divide by zero: no trap, zero result after one cycle
                            r_result <= '0;
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_signed <= signed_div_i;
                            r_sign1  <= signed_div_i & opdata1_i[W-1];
                            r_sign2  <= signed_div_i & opdata2_i[W-1];
                            r_dvd    <= w_abs1;
                            r_dvs    <= w_abs2;
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(W)) begin
                        // All quotient bits produced: publish corrected result
                        r_result <= {w_rmd, w_quot};
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_rem <= w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
                        r_dvd <= {r_dvd[W-2:0], w_qbit};
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    if (!start_i || ena) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq: directed scoreboard bench for div_seq. The driver pushes the
// hand-computed result for every request; a monitor pops and compares on each
// rising edge of ready_o.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    logic [63:0] sb_q[$];
    int          n_cmp;
    int          n_err;
    logic        mon_prev;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per ready_o rising edge
    always @(negedge clk) begin
        if (ready_o === 1'b1 && mon_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got result %h with no request expected", result_o);
            end else begin
                chk("sb_result", result_o, sb_q.pop_front());
            end
        end
        mon_prev = ready_o;
    end

    // Issue one request at the current time (just after a rising edge).
    // exp_edges counts rising edges from the drive, the accepting edge being 1.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_edges, input bit use_ena);
        int k;
        bit seen;
        sb_q.push_back(exp);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                // Operand changes after acceptance must not matter
                opdata1_i    = ~a;
                opdata2_i    = b + 32'd5;
                signed_div_i = ~s;
            end
            if (ready_o) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: ready_o not seen after %0d edges, required %0d", k, exp_edges);
            start_i = 1'b0;
            return;
        end
        chk("latency", 64'(k), 64'(exp_edges));
        // Held in DONE while start stays high and ena low
        repeat (2) begin @(posedge clk); #1; end
        chk("done_hold_rdy", 64'(ready_o), 64'd1);
        chk("done_hold_res", result_o, exp);
        if (use_ena) ena = 1'b1;
        else         start_i = 1'b0;
        @(posedge clk); #1;
        chk("done_exit_rdy", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        ena     = 1'b0;
    endtask

    initial begin
        bit rose;
        logic [63:0] prior;
        n_cmp = 0;
        n_err = 0;
        mon_prev = 1'b0;
        rst = 1'b1; ena = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0; start_i = 1'b0; annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", 64'(ready_o), 64'd0);
        chk("reset_res", result_o, 64'd0);
        rst = 1'b0;

        // 100/7 unsigned: q=14, r=2
        do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, 1'b0);
        // -7/2 signed: q=-3, r=-1
        do_div(32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        // same operands unsigned: 0xFFFFFFF9/2 = 0x7FFFFFFC r 1
        do_div(32'hFFFFFFF9, 32'h2, 1'b0, 64'h00000001_7FFFFFFC, 34, 1'b1);
        // divide by zero, both modes
        do_div(32'd12345, 32'd0, 1'b0, 64'h0, 1, 1'b0);
        do_div(32'hFFFFFFF9, 32'd0, 1'b1, 64'h0, 1, 1'b0);
        // most-negative / -1 truncates
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, 1'b0);
        // 100/-7 signed: q=-14, r=+2
        do_div(32'd100, 32'hFFFFFFF9, 1'b1, 64'h00000002_FFFFFFF2, 34, 1'b1);

        // start with annul held in IDLE is ignored
        prior = 64'h00000002_FFFFFFF2;
        opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
        start_i = 1'b1; annul_i = 1'b1;
        rose = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) rose = 1'b1; end
        chk("idle_annul_rdy", 64'(rose), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        // annul at BUSY step 10
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        rose = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) rose = 1'b1; end
        chk("annul_rdy", 64'(rose), 64'd0);
        chk("annul_res", result_o, prior);
        do_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, 34, 1'b0);

        // reset at BUSY step 20, then back-to-back request
        opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h10; signed_div_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy_rdy", 64'(ready_o), 64'd0);
        chk("rst_busy_res", result_o, 64'd0);
        rst = 1'b0;
        do_div(32'hDEADBEEF, 32'h10, 1'b0, 64'h0000000F_0DEADBEE, 34, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
